// File: rtl/halloween_sequencer_if.sv
// Bus between the Halloween sequencer and its surroundings: control inputs,
// the 4-slot opcode mux, the sound player handshake and the decoration drives.
interface halloween_sequencer_if;
    logic       start;
    logic       abort;
    logic       loop;
    logic [1:0] sel;
    logic [3:0] opcode;
    logic       powered;
    logic       light_en;
    logic [1:0] light_color;
    logic       sound_req;
    logic [1:0] sound_code;
    logic       sound_ack;
    logic       wave_hands;
    logic       move_jaw;
    logic       fog;
    logic       busy;
    logic       done;
    logic       err;

    // Sequencer side
    modport slave (
        input  start, abort, loop, opcode, sound_ack,
        output sel, powered, light_en, light_color, sound_req, sound_code,
               wave_hands, move_jaw, fog, busy, done, err
    );

    // Controller / environment side
    modport master (
        output start, abort, loop, opcode, sound_ack,
        input  sel, powered, light_en, light_color, sound_req, sound_code,
               wave_hands, move_jaw, fog, busy, done, err
    );
endinterface

// File: rtl/halloween_sequencer.sv
// Halloween decoration sequencer: walks the 4-slot opcode mux, decodes each
// opcode by category and drives lights, sound requests and timed effects.
module halloween_sequencer #(
    parameter int unsigned EFFECT_CYCLES = 8,
    parameter int unsigned SOUND_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    halloween_sequencer_if.slave  bus
);

    localparam int unsigned CW = (EFFECT_CYCLES > 1) ? $clog2(EFFECT_CYCLES) : 1;
    localparam int unsigned TW = (SOUND_TIMEOUT > 1) ? $clog2(SOUND_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_SOUND,
        S_EFFECT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t          r_state, w_state;
    logic [1:0]      r_sel, w_sel;
    logic [3:0]      r_op, w_op;
    logic            r_powered, w_powered;
    logic            r_light_en, w_light_en;
    logic [1:0]      r_light_color, w_light_color;
    logic            r_sound_req, w_sound_req;
    logic [1:0]      r_sound_code, w_sound_code;
    logic            r_wave, w_wave;
    logic            r_jaw, w_jaw;
    logic            r_fog, w_fog;
    logic            r_err, w_err;
    logic [TW-1:0]   r_timer, w_timer;
    logic [CW-1:0]   r_count, w_count;

    // State and datapath registers, cleared synchronously by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_sel         <= '0;
            r_op          <= '0;
            r_powered     <= 1'b0;
            r_light_en    <= 1'b0;
            r_light_color <= '0;
            r_sound_req   <= 1'b0;
            r_sound_code  <= '0;
            r_wave        <= 1'b0;
            r_jaw         <= 1'b0;
            r_fog         <= 1'b0;
            r_err         <= 1'b0;
            r_timer       <= '0;
            r_count       <= '0;
        end else begin
            r_state       <= w_state;
            r_sel         <= w_sel;
            r_op          <= w_op;
            r_powered     <= w_powered;
            r_light_en    <= w_light_en;
            r_light_color <= w_light_color;
            r_sound_req   <= w_sound_req;
            r_sound_code  <= w_sound_code;
            r_wave        <= w_wave;
            r_jaw         <= w_jaw;
            r_fog         <= w_fog;
            r_err         <= w_err;
            r_timer       <= w_timer;
            r_count       <= w_count;
        end
    end

    // Next-state and next-output logic; abort is applied last so it wins
    always_comb begin
        w_state       = r_state;
        w_sel         = r_sel;
        w_op          = r_op;
        w_powered     = r_powered;
        w_light_en    = r_light_en;
        w_light_color = r_light_color;
        w_sound_req   = r_sound_req;
        w_sound_code  = r_sound_code;
        w_wave        = r_wave;
        w_jaw         = r_jaw;
        w_fog         = r_fog;
        w_err         = r_err;
        w_timer       = r_timer;
        w_count       = r_count;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_sel   = '0;
                    w_err   = 1'b0;
                    w_state = S_FETCH;
                end
            end
            S_FETCH: begin
                w_op    = bus.opcode;
                w_state = S_EXEC;
            end
            S_EXEC: begin
                w_state = S_NEXT;
                if (r_op == 4'b0000) begin
                    w_powered = 1'b1;
                end else if (r_op == 4'b0001) begin
                    w_powered  = 1'b0;
                    w_light_en = 1'b0;
                    w_wave     = 1'b0;
                    w_jaw      = 1'b0;
                    w_fog      = 1'b0;
                    w_state    = S_DONE;
                end else if (r_powered) begin
                    // Unpowered non-system opcodes fall through as no-ops
                    case (r_op[3:2])
                        2'b01: begin
                            if (r_op[1:0] != 2'b11) begin
                                w_light_en    = 1'b1;
                                w_light_color = r_op[1:0];
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        2'b10: begin
                            if (r_op[1:0] != 2'b11) begin
                                w_sound_req  = 1'b1;
                                w_sound_code = r_op[1:0];
                                w_timer      = '0;
                                w_state      = S_SOUND;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        2'b11: begin
                            w_count = CW'(EFFECT_CYCLES - 1);
                            case (r_op[1:0])
                                2'b00: begin w_wave = 1'b1; w_state = S_EFFECT; end
                                2'b01: begin w_jaw  = 1'b1; w_state = S_EFFECT; end
                                2'b10: begin w_fog  = 1'b1; w_state = S_EFFECT; end
                                default: w_err = 1'b1;
                            endcase
                        end
                        default: w_err = 1'b1;
                    endcase
                end
            end
            S_SOUND: begin
                if (bus.sound_ack) begin
                    w_sound_req = 1'b0;
                    w_state     = S_NEXT;
                end else if (r_timer == TW'(SOUND_TIMEOUT - 1)) begin
                    w_sound_req = 1'b0;
                    w_err       = 1'b1;
                    w_state     = S_NEXT;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            S_EFFECT: begin
                if (r_count == '0) begin
                    w_wave  = 1'b0;
                    w_jaw   = 1'b0;
                    w_fog   = 1'b0;
                    w_state = S_NEXT;
                end else begin
                    w_count = r_count - 1'b1;
                end
            end
            S_NEXT: begin
                if (r_sel != 2'd3) begin
                    w_sel   = r_sel + 1'b1;
                    w_state = S_FETCH;
                end else if (bus.loop) begin
                    w_sel   = '0;
                    w_state = S_FETCH;
                end else begin
                    w_state = S_DONE;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // DONE is excluded so an abort held into DONE cannot re-pulse done
        if (bus.abort && (r_state != S_IDLE) && (r_state != S_DONE)) begin
            w_sound_req = 1'b0;
            w_wave      = 1'b0;
            w_jaw       = 1'b0;
            w_fog       = 1'b0;
            w_state     = S_DONE;
        end
    end

    assign bus.sel         = r_sel;
    assign bus.powered     = r_powered;
    assign bus.light_en    = r_light_en;
    assign bus.light_color = r_light_color;
    assign bus.sound_req   = r_sound_req;
    assign bus.sound_code  = r_sound_code;
    assign bus.wave_hands  = r_wave;
    assign bus.move_jaw    = r_jaw;
    assign bus.fog         = r_fog;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.err         = r_err;

endmodule

// File: tb/tb_halloween_sequencer.sv
// Directed bench for halloween_sequencer; cycle numbers follow the timing
// convention where the start-sampling cycle is cycle 0.
module tb_halloween_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] prog [4];
    int cyc;
    int n_checks = 0;
    int n_fail = 0;

    halloween_sequencer_if bus ();

    halloween_sequencer #(
        .EFFECT_CYCLES(8),
        .SOUND_TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.opcode = prog[bus.sel];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_seq();
        cyc = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.powered, bus.light_en, bus.light_color, bus.sound_req, bus.sound_code,
             bus.wave_hands, bus.move_jaw, bus.fog, bus.busy, bus.done, bus.err, bus.sel} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_state: outputs=%b required all zero", {bus.powered, bus.light_en,
                     bus.light_color, bus.sound_req, bus.sound_code, bus.wave_hands, bus.move_jaw,
                     bus.fog, bus.busy, bus.done, bus.err, bus.sel});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_colour();
        prog = '{4'b0000, 4'b0101, 4'b0110, 4'b0100};
        start_seq();
        while (cyc <= 14) begin
            if (cyc <= 12) begin
                n_checks++;
                if (bus.sel !== 2'((cyc - 1) / 3)) begin
                    n_fail++;
                    $display("FAIL colour_sel cyc=%0d: got %0d want %0d", cyc, bus.sel, (cyc - 1) / 3);
                end
            end
            n_checks++;
            if (bus.done !== (cyc == 13)) begin
                n_fail++;
                $display("FAIL colour_done cyc=%0d: got %b want %b", cyc, bus.done, cyc == 13);
            end
            tick();
        end
        n_checks++;
        if ({bus.powered, bus.light_en, bus.light_color, bus.err, bus.busy} !== 6'b110000) begin
            n_fail++;
            $display("FAIL colour_final: pwr/len/col/err/busy=%b want 110000",
                     {bus.powered, bus.light_en, bus.light_color, bus.err, bus.busy});
        end
    endtask

    task automatic test_fog();
        prog = '{4'b0000, 4'b1110, 4'b0100, 4'b0100};
        start_seq();
        while (cyc <= 22) begin
            n_checks++;
            if (bus.fog !== (cyc >= 6 && cyc <= 13)) begin
                n_fail++;
                $display("FAIL fog_pulse cyc=%0d: got %b want %b", cyc, bus.fog, cyc >= 6 && cyc <= 13);
            end
            n_checks++;
            if (bus.done !== (cyc == 21)) begin
                n_fail++;
                $display("FAIL fog_done cyc=%0d: got %b want %b", cyc, bus.done, cyc == 21);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_sound_ack();
        prog = '{4'b0000, 4'b1010, 4'b0100, 4'b0100};
        start_seq();
        while (cyc <= 18) begin
            bus.sound_ack = (cyc == 9);
            n_checks++;
            if (bus.sound_req !== (cyc >= 6 && cyc <= 9)) begin
                n_fail++;
                $display("FAIL snd_req cyc=%0d: got %b want %b", cyc, bus.sound_req, cyc >= 6 && cyc <= 9);
            end
            if (cyc == 6) begin
                n_checks++;
                if (bus.sound_code !== 2'b10) begin
                    n_fail++;
                    $display("FAIL snd_code: got %b want 10", bus.sound_code);
                end
            end
            n_checks++;
            if (bus.done !== (cyc == 17)) begin
                n_fail++;
                $display("FAIL snd_done cyc=%0d: got %b want %b", cyc, bus.done, cyc == 17);
            end
            tick();
        end
        bus.sound_ack = 1'b0;
        n_checks++;
        if (bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL snd_err: got %b want 0", bus.err);
        end
        tick();
    endtask

    task automatic test_sound_timeout();
        prog = '{4'b0000, 4'b1010, 4'b0100, 4'b0100};
        start_seq();
        while (cyc <= 30) begin
            n_checks++;
            if (bus.sound_req !== (cyc >= 6 && cyc <= 21)) begin
                n_fail++;
                $display("FAIL to_req cyc=%0d: got %b want %b", cyc, bus.sound_req, cyc >= 6 && cyc <= 21);
            end
            n_checks++;
            if (bus.err !== (cyc >= 22)) begin
                n_fail++;
                $display("FAIL to_err cyc=%0d: got %b want %b", cyc, bus.err, cyc >= 22);
            end
            n_checks++;
            if (bus.done !== (cyc == 29)) begin
                n_fail++;
                $display("FAIL to_done cyc=%0d: got %b want %b", cyc, bus.done, cyc == 29);
            end
            tick();
        end
    endtask

    task automatic test_unpowered();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        prog = '{4'b0100, 4'b0000, 4'b0111, 4'b0001};
        start_seq();
        while (cyc <= 13) begin
            n_checks++;
            if (bus.light_en !== 1'b0) begin
                n_fail++;
                $display("FAIL unp_light cyc=%0d: got %b want 0", cyc, bus.light_en);
            end
            n_checks++;
            if (bus.powered !== (cyc >= 6 && cyc <= 11)) begin
                n_fail++;
                $display("FAIL unp_pwr cyc=%0d: got %b want %b", cyc, bus.powered, cyc >= 6 && cyc <= 11);
            end
            n_checks++;
            if (bus.err !== (cyc >= 9)) begin
                n_fail++;
                $display("FAIL unp_err cyc=%0d: got %b want %b", cyc, bus.err, cyc >= 9);
            end
            n_checks++;
            if (bus.done !== (cyc == 12)) begin
                n_fail++;
                $display("FAIL unp_done cyc=%0d: got %b want %b", cyc, bus.done, cyc == 12);
            end
            tick();
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL unp_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_loop_abort();
        prog = '{4'b0000, 4'b1100, 4'b1001, 4'b0100};
        bus.loop = 1'b1;
        bus.sound_ack = 1'b1;
        start_seq();
        while (cyc <= 28) begin
            n_checks++;
            if (bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL loop_done cyc=%0d: got %b want 0", cyc, bus.done);
            end
            n_checks++;
            if (bus.wave_hands !== ((cyc >= 6 && cyc <= 13) || cyc >= 27)) begin
                n_fail++;
                $display("FAIL loop_wave cyc=%0d: got %b", cyc, bus.wave_hands);
            end
            n_checks++;
            if (bus.sound_req !== (cyc == 17)) begin
                n_fail++;
                $display("FAIL loop_req cyc=%0d: got %b want %b", cyc, bus.sound_req, cyc == 17);
            end
            if (cyc == 17) begin
                n_checks++;
                if (bus.sound_code !== 2'b01) begin
                    n_fail++;
                    $display("FAIL loop_code: got %b want 01", bus.sound_code);
                end
            end
            if (cyc == 19 || cyc == 22) begin
                n_checks++;
                if (bus.sel !== ((cyc == 19) ? 2'd3 : 2'd0)) begin
                    n_fail++;
                    $display("FAIL loop_sel cyc=%0d: got %0d want %0d", cyc, bus.sel, (cyc == 19) ? 3 : 0);
                end
            end
            if (cyc == 28) bus.abort = 1'b1;
            tick();
        end
        bus.abort = 1'b0;
        n_checks++;
        if ({bus.wave_hands, bus.done, bus.busy} !== 3'b011) begin
            n_fail++;
            $display("FAIL abort_next: wave/done/busy=%b want 011", {bus.wave_hands, bus.done, bus.busy});
        end
        tick();
        n_checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_idle: done/busy=%b want 00", {bus.done, bus.busy});
        end
        bus.loop = 1'b0;
        bus.sound_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        prog = '{4'b0000, 4'b1110, 4'b0100, 4'b0100};
        start_seq();
        while (cyc < 8) tick();
        n_checks++;
        if (bus.fog !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pre: fog=%b want 1", bus.fog);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({bus.powered, bus.light_en, bus.light_color, bus.sound_req, bus.sound_code,
             bus.wave_hands, bus.move_jaw, bus.fog, bus.busy, bus.done, bus.err, bus.sel} !== 15'd0) begin
            n_fail++;
            $display("FAIL rmid_state: outputs=%b required all zero", {bus.powered, bus.light_en,
                     bus.light_color, bus.sound_req, bus.sound_code, bus.wave_hands, bus.move_jaw,
                     bus.fog, bus.busy, bus.done, bus.err, bus.sel});
        end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.loop = 1'b0;
        bus.sound_ack = 1'b0;
        prog = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        cyc = 0;
        test_reset();
        test_colour();
        test_fog();
        test_sound_ack();
        test_sound_timeout();
        test_unpowered();
        test_loop_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
